cdc_slow_tx: RTL

Slow-domain sender that feeds the multibit slow-to-fast CDC capture stage. Accepts 32-bit words on a valid/ready stream and buffers them in a small FIFO. Presents each word on `din` with a `din_en` pulse of fixed high and low duration, so the fast-domain two-flop enable synchronizer sees a clean rising edge while `din` is held stable. Runs entirely in the slow (20 MHz) domain; `din`/`din_en` cross to the 100 MHz domain.

---
 rtl/cdc_slow_tx.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/cdc_slow_tx.sv
// Slow-domain sender for the slow-to-fast multibit CDC: FIFO-buffered words presented on din with a fixed HIGH/LOW din_en pulse.
// Optional build macro CDC_TX_PARITY_EN adds din_par, the even parity of the loaded word.
`timescale 1ns/1ps
module cdc_slow_tx #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int HOLD  = 2,
  parameter int GAP   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW-1:0]            s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [DW-1:0]            din,
  output logic                     din_en,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
`ifdef CDC_TX_PARITY_EN
  ,
  output logic                     din_par
`endif
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int CMAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [1:0]    ST_IDLE  = 2'd0;
  localparam logic [1:0]    ST_HIGH  = 2'd1;
  localparam logic [1:0]    ST_LOW   = 2'd2;

  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [LW-1:0] LVL_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP - 1);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic [1:0]    state_r;
  logic [CW-1:0] cnt_r;
  logic [DW-1:0] din_r;
  logic          din_en_r;

  logic          empty_s;
  logic          full_s;
  logic          push_s;
  logic          pop_s;
  logic [DW-1:0] head_s;

  assign empty_s = (level_r == LVL_ZERO);
  assign full_s  = (level_r == LVL_FULL);
  assign push_s  = s_valid && !full_s;
  assign head_s  = mem_r[rd_ptr_r];

  assign s_ready = !full_s;
  assign din     = din_r;
  assign din_en  = din_en_r;
  assign level   = level_r;
  assign busy    = (state_r != ST_IDLE) || !empty_s;

  // Pop the head whenever the pulse engine is ready for a new word.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      ST_IDLE: pop_s = !empty_s;
      ST_LOW:  pop_s = (cnt_r == CNT_ZERO) && !empty_s;
      default: pop_s = 1'b0;
    endcase
  end

  // Storage array; reset only touches pointers so the array needs no reset.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_r[wr_ptr_r] <= s_data;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves level unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LVL_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // Pulse engine: a load starts HIGH for HOLD cycles, then LOW for GAP cycles; din only changes on a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_ZERO;
      din_r    <= {DW{1'b0}};
      din_en_r <= 1'b0;
    end else if (pop_s) begin
      din_r    <= head_s;
      din_en_r <= 1'b1;
      cnt_r    <= HOLD_LD;
      state_r  <= ST_HIGH;
    end else begin
      case (state_r)
        ST_IDLE: state_r <= ST_IDLE;
        ST_HIGH: begin
          if (cnt_r == CNT_ZERO) begin
            din_en_r <= 1'b0;
            cnt_r    <= GAP_LD;
            state_r  <= ST_LOW;
          end else begin
            cnt_r    <= cnt_r - CNT_ONE;
          end
        end
        ST_LOW: begin
          if (cnt_r != CNT_ZERO) begin
            cnt_r   <= cnt_r - CNT_ONE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          din_en_r <= 1'b0;
          cnt_r    <= CNT_ZERO;
        end
      endcase
    end
  end

`ifdef CDC_TX_PARITY_EN
  logic din_par_r;

  function automatic logic even_par(input logic [DW-1:0] word);
    return ^word;
  endfunction

  assign din_par = din_par_r;

  // Parity travels with the word and is captured on the same load edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      din_par_r <= 1'b0;
    end else if (pop_s) begin
      din_par_r <= even_par(head_s);
    end else begin
      din_par_r <= din_par_r;
    end
  end
`endif

endmodule
